bio_bus: RTL
============

BIO_BUS -- requirements
Module: bio_bus

Interface
REQ-001 Parameter WIDTH, default 8: pad bus width in bits; legal range 1..64.
REQ-002 Parameter TURN_CYCLES, default 2: bus-release cycles on every direction change; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 dir_req  input  1  requested direction: 1 = drive the pads, 0 = release and receive.
REQ-006 tx_data  input  WIDTH  word to drive.
REQ-007 tx_valid  input  1  tx_data is valid.
REQ-008 tx_ready  output  1  a word is accepted when tx_valid and tx_ready are both 1 at a clock edge.
REQ-009 rx_data  output  WIDTH  sampled pad value.
REQ-010 rx_valid  output  1  rx_data holds a pad sample taken while the bus was released.
REQ-011 oe  output  1  pads are driven by this block.
REQ-012 busy  output  1  turnaround is in progress.
REQ-013 bio  inout  WIDTH  pads; driven with out_reg when oe=1, otherwise all bits high-impedance.

Function
REQ-014 The block SHALL have exactly three states: RX (released), TURN (released, counting), TX (driving).
REQ-015 RX with dir_req=1 SHALL go to TURN. TX with dir_req=0 SHALL go to TURN. Otherwise the state SHALL hold.
REQ-016 On entry to TURN, a counter SHALL load TURN_CYCLES-1 and decrement once per cycle. At zero, the next state SHALL be TX if dir_req=1, else RX, sampled that cycle.
REQ-017 The pads SHALL stay high-impedance for at least TURN_CYCLES full cycles between any drive by this block and any sample, and vice versa.
REQ-018 oe SHALL be registered: oe=1 exactly when state=TX. busy=1 exactly when state=TURN.
REQ-019 tx_ready SHALL be combinational: state=TX and dir_req=1.
REQ-020 On an accepted word, out_reg SHALL load tx_data at that edge and appear on bio in the next cycle.
REQ-021 out_reg SHALL hold its value otherwise, including across TURN and RX. On re-entry to TX the last accepted word SHALL be driven.
REQ-022 tx_valid SHALL be ignored when tx_ready=0, with no buffering.
REQ-023 In RX, bio SHALL be sampled every cycle through the receive pipeline of latency L cycles (see REQ-030), and rx_data SHALL be the pipeline output.
REQ-024 In TURN and TX, the receive pipeline and rx_data SHALL hold their values.
REQ-025 rx_valid SHALL be 1 only after L consecutive cycles in RX, and SHALL drop in the same cycle the state leaves RX.
REQ-026 A dir_req toggle during TURN SHALL NOT restart the counter; only its value at counter zero matters.
REQ-027 If the counter expires with dir_req equal to the pre-turn direction, the block SHALL return to that state (no glitch drive).

Reset
REQ-028 While rst=1: state=RX, oe=0, bio all high-impedance, busy=0, tx_ready=0, rx_valid=0, rx_data=0, out_reg=0, counter=0, receive pipeline=0.
REQ-029 Reset asserted mid-TX or mid-TURN SHALL release the pads immediately and asynchronously. After reset release, the first cycle SHALL be RX with rx_valid=0.

Configuration
REQ-030 Macro BIO_BUS_SYNC_EN.
- Defined: the receive path SHALL be a two-flop synchroniser followed by rx_data, giving L=2.
- Undefined: bio SHALL be registered once directly into rx_data, giving L=1.
- All other behaviour SHALL be identical.

Verification
REQ-031 Reset: WIDTH=8, drive rst=1 mid-TX with out_reg=8'hA5 -> bio=8'hZZ the same cycle, oe=0, rx_data=8'h00, rx_valid=0.
REQ-032 RX->TX: TURN_CYCLES=2, dir_req 0->1 at cycle 0 -> busy=1 cycles 1-2, oe=1 and tx_ready=1 from cycle 3, bio=8'h00 until a write.
REQ-033 Write: in TX, tx_valid=1, tx_data=8'h3C at edge n -> bio=8'h3C from cycle n+1. tx_valid=1 with dir_req=0 -> not accepted, out_reg unchanged.
REQ-034 TX->RX receive: external driver puts 8'h5A on bio after TURN -> rx_valid=1 with rx_data=8'h5A after L cycles in RX (L=2 with BIO_BUS_SYNC_EN, 1 without). rx_data holds 8'h5A through a following TURN.
REQ-035 Toggle in TURN: TURN_CYCLES=3, dir_req 1 then 0 then 1 inside TURN -> TURN lasts exactly 3 cycles, ends in TX, and oe never pulses during TURN.
REQ-036 Contention check: across 20 random direction changes, cycles with oe=1 and an external driver active -> 0.

Source files
------------

// File: rtl/bio_bus.sv
// Bidirectional pad controller: TX drives, RX receives, TURN keeps the pads released between them.
// Optional BIO_BUS_SYNC_EN adds a two-flop synchroniser in front of rx_data (latency 2 instead of 1).
module bio_bus #(
    parameter int WIDTH       = 8,
    parameter int TURN_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dir_req,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             oe,
    output logic             busy,
    inout  wire  [WIDTH-1:0] bio
);

    localparam logic [1:0] S_RX   = 2'd0;
    localparam logic [1:0] S_TURN = 2'd1;
    localparam logic [1:0] S_TX   = 2'd2;

    localparam logic [3:0] TURN_LOAD = 4'(TURN_CYCLES - 1);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [3:0]       cnt;
    logic [3:0]       cnt_nxt;
    logic [WIDTH-1:0] out_reg;
    logic             accept;
    logic             in_rx;
    logic             stay_rx;

    // Direction changes always pass through TURN; dir_req only matters again at counter zero.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_RX: begin
                if (dir_req) begin
                    state_nxt = S_TURN;
                    cnt_nxt   = TURN_LOAD;
                end
            end
            S_TURN: begin
                if (cnt == 4'd0) begin
                    state_nxt = dir_req ? S_TX : S_RX;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            S_TX: begin
                if (!dir_req) begin
                    state_nxt = S_TURN;
                    cnt_nxt   = TURN_LOAD;
                end
            end
            default: begin
                state_nxt = S_RX;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    assign tx_ready = (state == S_TX) && dir_req;
    assign accept   = tx_valid && tx_ready;
    assign in_rx    = (state == S_RX);
    assign stay_rx  = in_rx && (state_nxt == S_RX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_RX;
            cnt   <= 4'd0;
            oe    <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            oe    <= (state_nxt == S_TX);
            busy  <= (state_nxt == S_TURN);
        end
    end

    // Last accepted word survives TURN and RX so re-entry to TX drives it again.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_reg <= '0;
        end else if (accept) begin
            out_reg <= tx_data;
        end
    end

    // oe is cleared asynchronously by rst, so the pads release immediately.
    assign bio = oe ? out_reg : {WIDTH{1'bz}};

`ifdef BIO_BUS_SYNC_EN
    logic [WIDTH-1:0] sync_p0;
    logic             vld_p0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0  <= '0;
            rx_data  <= '0;
            vld_p0   <= 1'b0;
            rx_valid <= 1'b0;
        end else begin
            if (in_rx) begin
                sync_p0 <= bio;
                rx_data <= sync_p0;
            end
            vld_p0   <= stay_rx;
            rx_valid <= stay_rx && vld_p0;
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            if (in_rx) begin
                rx_data <= bio;
            end
            rx_valid <= stay_rx;
        end
    end
`endif

endmodule
